// File: rtl/fwd_pkg.sv
// Shared operand-forwarding definitions: the 2-bit source select used by the
// per-operand selector and the operand latch.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_EX  = 2'b11
  } fwd_sel_t;

endpackage : fwd_pkg

// File: rtl/operand_fwd_unit_if.sv
// ID/EX forwarding bus: ID operands, in-flight writes from EX/MEM/WB, and the
// operand-latch/stall outputs. master = pipeline side, slave = forwarding unit.
interface operand_fwd_unit_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
);

  logic                        id_valid;
  logic [NUM_SRC-1:0]          id_src_used;
  logic [NUM_SRC*REG_AW-1:0]   id_src_addr;
  logic [NUM_SRC*DATA_W-1:0]   id_rf_data;
  logic                        ex_wr_en;
  logic                        ex_is_load;
  logic [REG_AW-1:0]           ex_wr_addr;
  logic [DATA_W-1:0]           ex_result;
  logic                        mem_wr_en;
  logic [REG_AW-1:0]           mem_wr_addr;
  logic [DATA_W-1:0]           mem_data;
  logic                        wb_wr_en;
  logic [REG_AW-1:0]           wb_wr_addr;
  logic [DATA_W-1:0]           wb_data;
  logic                        ex_ready;
  logic                        stall_clr;
  logic                        id_stall;
  logic                        ex_valid;
  logic [NUM_SRC*DATA_W-1:0]   ex_op_data;
  logic [NUM_SRC*2-1:0]        ex_fwd_sel;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output id_valid, id_src_used, id_src_addr, id_rf_data,
           ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
           mem_wr_en, mem_wr_addr, mem_data,
           wb_wr_en, wb_wr_addr, wb_data,
           ex_ready, stall_clr,
    input  id_stall, ex_valid, ex_op_data, ex_fwd_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_used, id_src_addr, id_rf_data,
           ex_wr_en, ex_is_load, ex_wr_addr, ex_result,
           mem_wr_en, mem_wr_addr, mem_data,
           wb_wr_en, wb_wr_addr, wb_data,
           ex_ready, stall_clr,
    output id_stall, ex_valid, ex_op_data, ex_fwd_sel, stall_cnt
  );

endinterface : operand_fwd_unit_if

// File: rtl/fwd_sel_1op.sv
// Single-operand forwarding selector: youngest-writer priority compare,
// load-use hazard flag and the 4:1 data mux. Purely combinational.
module fwd_sel_1op
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              src_used_i,
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              ex_wr_en_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_wr_addr_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] mem_wr_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wb_wr_en_i,
  input  logic [REG_AW-1:0] wb_wr_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output fwd_sel_t          sel_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hazard_o
);

  logic live;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  // r0 and unused operands never match any writer.
  assign live    = src_used_i && (src_addr_i != '0);
  assign ex_hit  = live && ex_wr_en_i  && (ex_wr_addr_i  == src_addr_i);
  assign mem_hit = live && mem_wr_en_i && (mem_wr_addr_i == src_addr_i);
  assign wb_hit  = live && wb_wr_en_i  && (wb_wr_addr_i  == src_addr_i);

  assign hazard_o = ex_hit && ex_is_load_i;

  always_comb begin
    sel_o  = FWD_RF;
    data_o = rf_data_i;
    if (ex_hit) begin
      // A load in EX masks older writers; the latch takes a bubble instead.
      if (!ex_is_load_i) begin
        sel_o  = FWD_EX;
        data_o = ex_result_i;
      end
    end else if (mem_hit) begin
      sel_o  = FWD_MEM;
      data_o = mem_data_i;
    end else if (wb_hit) begin
      sel_o  = FWD_WB;
      data_o = wb_data_i;
    end
  end

endmodule : fwd_sel_1op

// File: rtl/operand_fwd_unit.sv
// ID->EX operand forwarding stage: per-operand selectors, EX operand latch
// with load-use bubble and back-pressure hold, and a saturating stall counter.
module operand_fwd_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clk,
  input logic                rst_n,
  operand_fwd_unit_if.slave  bus
);

  logic [NUM_SRC*DATA_W-1:0] sel_data;
  logic [NUM_SRC*2-1:0]      sel_code;
  logic [NUM_SRC-1:0]        hazard;
  logic                      load_use;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_sel_t sel_w;

    fwd_sel_1op #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_sel (
      .src_used_i    (bus.id_src_used[g]),
      .src_addr_i    (bus.id_src_addr[g*REG_AW +: REG_AW]),
      .rf_data_i     (bus.id_rf_data[g*DATA_W +: DATA_W]),
      .ex_wr_en_i    (bus.ex_wr_en),
      .ex_is_load_i  (bus.ex_is_load),
      .ex_wr_addr_i  (bus.ex_wr_addr),
      .ex_result_i   (bus.ex_result),
      .mem_wr_en_i   (bus.mem_wr_en),
      .mem_wr_addr_i (bus.mem_wr_addr),
      .mem_data_i    (bus.mem_data),
      .wb_wr_en_i    (bus.wb_wr_en),
      .wb_wr_addr_i  (bus.wb_wr_addr),
      .wb_data_i     (bus.wb_data),
      .sel_o         (sel_w),
      .data_o        (sel_data[g*DATA_W +: DATA_W]),
      .hazard_o      (hazard[g])
    );

    assign sel_code[g*2 +: 2] = sel_w;
  end

  assign load_use     = bus.id_valid && (|hazard);
  assign bus.id_stall = !bus.ex_ready || load_use;

  logic                      ex_valid_q,   ex_valid_d;
  logic [NUM_SRC*DATA_W-1:0] ex_op_data_q, ex_op_data_d;
  logic [NUM_SRC*2-1:0]      ex_fwd_sel_q, ex_fwd_sel_d;
  logic [CNT_W-1:0]          stall_cnt_q,  stall_cnt_d;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op_data_d = ex_op_data_q;
    ex_fwd_sel_d = ex_fwd_sel_q;
    if (bus.ex_ready) begin
      if (load_use) begin
        ex_valid_d   = 1'b0;
        ex_op_data_d = '0;
        ex_fwd_sel_d = '0;
      end else begin
        ex_valid_d   = bus.id_valid;
        ex_op_data_d = sel_data;
        ex_fwd_sel_d = sel_code;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stall_clr) begin
      stall_cnt_d = '0;
    end else if (bus.id_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_op_data_q <= '0;
      ex_fwd_sel_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op_data_q <= ex_op_data_d;
      ex_fwd_sel_q <= ex_fwd_sel_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_op_data = ex_op_data_q;
  assign bus.ex_fwd_sel = ex_fwd_sel_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule : operand_fwd_unit
